// File: rtl/repeat_scan_pkg.sv
// repeat_scan_pkg: shared widths and FSM state encoding for the repeat scanner.
`default_nettype none

package repeat_scan_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_LEN   = 3'd1,
    S_WAIT_LEN = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/repeat_scan_mem.sv
// repeat_scan_mem: preloaded ROM-style array with a registered read port.
`default_nettype none

module repeat_scan_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents come from outside (initialisation or hierarchical force); no write port.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    rdata_o <= mem[addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/repeat_scan_top.sv
// repeat_scan_top: streams mem[1..mem[0]] out and counts values already seen earlier.
`default_nettype none

module repeat_scan_top
  import repeat_scan_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              done,
  output logic              valid,
  output logic              repeats_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] repeats
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic [DEPTH-1:0]    seen_q;
  logic [DATA_W-1:0]   cnt_q;
  logic                issue_q;
  logic                valid_q, done_q, rv_q;
  logic [DATA_W-1:0]   data_q, rep_q;
  logic [DATA_W-1:0]   rdata;

  repeat_scan_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) mem_inst (
    .clk     (clk),
    .addr_i  (addr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_LEN;
          addr_d  = '0;
        end
      end
      S_RD_LEN:   state_d = S_WAIT_LEN;
      S_WAIT_LEN: begin
        len_d = rdata;
        if (rdata == '0) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_STREAM;
          addr_d  = ADDR_W'(1);
        end
      end
      // Address holds at N after its last issue so it never wraps.
      S_STREAM: begin
        if (addr_q == len_q) state_d = S_DRAIN;
        else                 addr_d  = addr_q + ADDR_W'(1);
      end
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      data_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      // issue_q marks that rdata will hold a streamed element after this edge.
      issue_q <= (state_q == S_STREAM);
      valid_q <= issue_q;
      done_q  <= (state_q == S_FINISH);
      rv_q    <= (state_q == S_FINISH);
      if (state_q == S_FINISH) rep_q <= cnt_q;
      if (issue_q) data_q <= rdata;
      if (state_q == S_IDLE && start) begin
        seen_q <= '0;
        cnt_q  <= '0;
      end else if (issue_q) begin
        if (seen_q[rdata] && cnt_q != {DATA_W{1'b1}}) cnt_q <= cnt_q + DATA_W'(1);
        seen_q[rdata] <= 1'b1;
      end
    end
  end

  assign valid         = valid_q;
  assign done          = done_q;
  assign repeats_valid = rv_q;
  assign data_out      = data_q;
  assign repeats       = rep_q;

endmodule

`default_nettype wire

// File: tb/tb_repeat_scan_top.sv
// tb_repeat_scan_top: table-driven and randomized scans checked against a reference model.
`default_nettype none

module tb_repeat_scan_top;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       done, valid, repeats_valid;
  logic [7:0] data_out, repeats;

  int checks = 0;
  int failures = 0;
  int img [0:255];

  typedef struct {
    int n;
    int kind;     // 0 identity, 1 {7,7,3,7,3}, 2 zeros, 3 small random, 4 full random
    int exp_rep;  // -1: take the reference model's answer
  } vec_t;

  repeat_scan_top dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .done          (done),
    .valid         (valid),
    .repeats_valid (repeats_valid),
    .data_out      (data_out),
    .repeats       (repeats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_repeats(input int n);
    bit seen [256];
    int c = 0;
    for (int i = 1; i <= n; i++) begin
      if (seen[img[i]]) c = (c < 255) ? c + 1 : 255;
      seen[img[i]] = 1'b1;
    end
    return c;
  endfunction

  task automatic fill(input int n, input int kind);
    int pat [5] = '{7, 7, 3, 7, 3};
    img[0] = n;
    for (int i = 1; i < 256; i++) begin
      if (i > n)            img[i] = int'($urandom_range(0, 255));
      else if (kind == 0)   img[i] = i;
      else if (kind == 1)   img[i] = pat[(i - 1) % 5];
      else if (kind == 2)   img[i] = 0;
      else if (kind == 3)   img[i] = int'($urandom_range(0, 15));
      else                  img[i] = int'($urandom_range(0, 255));
    end
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = img[i][7:0];
  endtask

  // Called at a falling edge with the DUT idle; T0 is the next rising edge.
  task automatic scan(input int n, input int exp_rep, input int extra_at);
    int  last;
    bit  ev;
    last  = (n == 0) ? 3 : 4 + n;
    start = 1'b1;
    for (int k = 0; k <= last + 5; k++) begin
      @(negedge clk);
      start = (extra_at == k + 1);
      ev = (n > 0) && (k >= 4) && (k <= 3 + n);
      chk("valid", valid, ev);
      if (ev) chk("data_out", data_out, img[k - 3]);
      chk("done", done, k == last);
      chk("repeats_valid", repeats_valid, k == last);
      if (k == last) chk("repeats", repeats, exp_rep);
      if (k > last && n > 0) chk("data_out_hold", data_out, img[n]);
      if (k > last) chk("repeats_hold", repeats, exp_rep);
    end
    start = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int er;
    vecs = '{
      '{120, 0, 0},
      '{5,   1, 3},
      '{0,   2, 0},
      '{255, 2, 254},
      '{1,   3, 0},
      '{17,  3, -1},
      '{40,  4, -1},
      '{200, 3, -1}
    };

    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_repeats_valid", repeats_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_repeats", repeats, 0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      fill(vecs[v].n, vecs[v].kind);
      er = (vecs[v].exp_rep < 0) ? model_repeats(vecs[v].n) : vecs[v].exp_rep;
      scan(vecs[v].n, er, 0);
    end

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 60));
      fill(n, 3);
      scan(n, model_repeats(n), 0);
    end

    // Start during streaming is ignored; then back-to-back rescans of the same image.
    fill(5, 1);
    scan(5, 3, 6);
    scan(5, 3, 9);
    scan(5, 3, 0);

    // Asynchronous reset mid-stream aborts with no done, then a full scan works.
    fill(50, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_repeats", repeats, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_done", done, 0);
      chk("midrst_repeats_valid", repeats_valid, 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    scan(50, model_repeats(50), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
